// File: rtl/wb_regport_pkg.sv
// Shared types and defaults for the Wishbone-to-register-port bridge.
// The byte-merge helper builds the write word of a read-modify-write.
package wb_regport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW,
        ST_WR,
        ST_RESP
    } state_e;

    localparam int         DEF_REG_AW   = 2;
    localparam int         DEF_NUM_REGS = 3;
    localparam logic [2:0] DEF_WR_MASK  = 3'b011;

    function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                               input logic [31:0] new_dat,
                                               input logic [31:0] old_dat);
        logic [31:0] m;
        m = old_dat;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[b*8 +: 8] = new_dat[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_regport_bridge_if.sv
// Wishbone classic slave signals plus the peripheral register port.
// Names are seen from the bridge: _i are driven by the bus/peripheral side.
interface wb_regport_bridge_if
    import wb_regport_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              reg_we;
    logic [REG_AW-1:0] reg_addr;
    logic [31:0]       reg_din;
    logic [31:0]       reg_dout;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output reg_we, reg_addr, reg_din,
        input  reg_dout
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  reg_we, reg_addr, reg_din,
        output reg_dout
    );

endinterface

// File: rtl/wb_regport_bridge.sv
// Wishbone classic slave driving a single-cycle register port; partial writes become RMW.
// Latency request->ack/err: 1 (error, sel=0 write), 2 (read, full write), 3 (partial write).
// No backpressure from the register port; a RESP cycle after each access prevents resampling.
module wb_regport_bridge
    import wb_regport_pkg::*;
#(
    parameter int                  REG_AW   = DEF_REG_AW,
    parameter int                  NUM_REGS = DEF_NUM_REGS,
    parameter logic [NUM_REGS-1:0] WR_MASK  = DEF_WR_MASK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_regport_bridge_if.slave   bus
);

    state_e            state_q, state_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [3:0]        sel_q, sel_d;

    logic              req;
    logic [REG_AW-1:0] idx;
    logic              wr_ok;
    logic              bad;
    logic              unused_adr;

    assign req        = bus.wb_cyc_i & bus.wb_stb_i;
    assign idx        = bus.wb_adr_i[REG_AW+1:2];
    assign unused_adr = ^bus.wb_adr_i[31:REG_AW+2];

    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) wr_ok = WR_MASK[i];
        end
    end

    // A sel=0 write touches nothing, so it is acked even on a read-only index.
    assign bad = (bus.wb_adr_i[1:0] != 2'b00)
              || (int'(idx) >= NUM_REGS)
              || (bus.wb_we_i && !wr_ok && (bus.wb_sel_i != 4'h0));

    always_comb begin
        state_d = state_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!bus.wb_we_i) begin
                        addr_d  = idx;
                        state_d = ST_RD;
                    end else if (bus.wb_sel_i == 4'h0) begin
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (bus.wb_sel_i == 4'hF) begin
                        addr_d  = idx;
                        din_d   = bus.wb_dat_i;
                        we_d    = 1'b1;
                        state_d = ST_WR;
                    end else begin
                        addr_d  = idx;
                        wdat_d  = bus.wb_dat_i;
                        sel_d   = bus.wb_sel_i;
                        state_d = ST_RMW;
                    end
                end
            end
            ST_RD: begin
                if (!bus.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rdat_d  = bus.reg_dout;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RMW: begin
                if (!bus.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    din_d   = byte_merge(sel_q, wdat_q, bus.reg_dout);
                    we_d    = 1'b1;
                    state_d = ST_WR;
                end
            end
            // The write strobe has already gone out; only the ack depends on cyc.
            ST_WR: begin
                if (bus.wb_cyc_i) begin
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.wb_dat_o = rdat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.reg_we   = we_q;
    assign bus.reg_addr = addr_q;
    assign bus.reg_din  = din_q;

endmodule

// File: tb/tb_wb_regport_bridge.sv
// Directed bench for wb_regport_bridge with a three-register timer-like peripheral model.
// Register 2 is a read-only constant; register model resets with rst_n.
module tb_wb_regport_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    wb_regport_bridge_if #(.REG_AW(2)) bus();

    wb_regport_bridge #(
        .REG_AW   (2),
        .NUM_REGS (3),
        .WR_MASK  (3'b011)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] regs [0:3];
    int          we_cnt;
    logic [1:0]  last_addr;
    logic [31:0] last_din;

    assign bus.reg_dout = regs[bus.reg_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs[0]   <= 32'h0000_0001;
            regs[1]   <= 32'h0000_0000;
            regs[2]   <= 32'h1234_5678;
            regs[3]   <= 32'hDEAD_BEEF;
        end else if (bus.reg_we) begin
            regs[bus.reg_addr] <= bus.reg_din;
            we_cnt    <= we_cnt + 1;
            last_addr <= bus.reg_addr;
            last_din  <= bus.reg_din;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Drives one request from posedge+1 and waits (bounded) for ack/err; returns at posedge+1 after RESP.
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output logic ack,
                           output logic err, output logic [31:0] rdat, output logic [9:0] we_tr);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        lat = 0; ack = 1'b0; err = 1'b0; we_tr = '0;
        while (lat < 10 && !(ack || err)) begin
            @(posedge clk); #1;
            we_tr[lat] = bus.reg_we;
            lat++;
            ack = bus.wb_ack_o;
            err = bus.wb_err_o;
        end
        rdat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.wb_ack_o, bus.wb_err_o, bus.reg_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got ack/err/we=%b want 000", {bus.wb_ack_o, bus.wb_err_o, bus.reg_we});
        end
        n_cmp++;
        if ({bus.wb_dat_o, bus.reg_din, bus.reg_addr} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_data: got dat_o=%h din=%h addr=%0d want all 0", bus.wb_dat_o, bus.reg_din, bus.reg_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.wb_ack_o, bus.wb_err_o, bus.reg_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got ack/err/we=%b want 000", {bus.wb_ack_o, bus.wb_err_o, bus.reg_we});
        end
    endtask

    task automatic test_full_write();
        int lat; logic ack, err; logic [31:0] rdat; logic [9:0] wt; int c0;
        c0 = we_cnt;
        do_xfer(1'b1, 32'h04, 32'h0000_0064, 4'hF, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 2 || ack !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wr_resp: got lat=%0d ack=%b err=%b want lat=2 ack=1 err=0", lat, ack, err);
        end
        n_cmp++;
        if (wt !== 10'b00_0000_0001 || we_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL full_wr_we: got trace=%b pulses=%0d want trace=0000000001 pulses=1", wt, we_cnt - c0);
        end
        n_cmp++;
        if (last_addr !== 2'd1 || last_din !== 32'h64) begin
            n_fail++;
            $display("FAIL full_wr_data: got addr=%0d din=%h want addr=1 din=00000064", last_addr, last_din);
        end
        n_cmp++;
        if (bus.wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wr_ack_len: ack still %b one cycle later, want 0", bus.wb_ack_o);
        end
        do_xfer(1'b0, 32'h04, 32'h0, 4'hF, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 2 || ack !== 1'b1 || rdat !== 32'h64 || wt !== 10'd0) begin
            n_fail++;
            $display("FAIL read_back: got lat=%0d ack=%b dat=%h we_trace=%b want lat=2 ack=1 dat=00000064 we_trace=0", lat, ack, rdat, wt);
        end
    endtask

    task automatic test_partial_write();
        int lat; logic ack, err; logic [31:0] rdat; logic [9:0] wt; int c0;
        c0 = we_cnt;
        do_xfer(1'b1, 32'h00, 32'hAABB_CCDD, 4'b0010, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 3 || ack !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL part_wr_resp: got lat=%0d ack=%b err=%b want lat=3 ack=1 err=0", lat, ack, err);
        end
        n_cmp++;
        if (wt !== 10'b00_0000_0010 || we_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL part_wr_we: got trace=%b pulses=%0d want trace=0000000010 pulses=1", wt, we_cnt - c0);
        end
        n_cmp++;
        if (last_addr !== 2'd0 || last_din !== 32'h0000_CC01) begin
            n_fail++;
            $display("FAIL part_wr_merge: got addr=%0d din=%h want addr=0 din=0000cc01", last_addr, last_din);
        end
        do_xfer(1'b0, 32'h00, 32'h0, 4'hF, lat, ack, err, rdat, wt);
        n_cmp++;
        if (rdat !== 32'h0000_CC01 || lat !== 2) begin
            n_fail++;
            $display("FAIL part_wr_readback: got dat=%h lat=%0d want dat=0000cc01 lat=2", rdat, lat);
        end
    endtask

    task automatic test_errors();
        logic        ev_we  [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ev_adr [3] = '{32'h08, 32'h0C, 32'h02};
        int lat; logic ack, err; logic [31:0] rdat; logic [9:0] wt; int c0;
        for (int k = 0; k < 3; k++) begin
            c0 = we_cnt;
            do_xfer(ev_we[k], ev_adr[k], 32'hFFFF_FFFF, 4'hF, lat, ack, err, rdat, wt);
            n_cmp++;
            if (lat !== 1 || err !== 1'b1 || ack !== 1'b0 || we_cnt !== c0 || wt !== 10'd0) begin
                n_fail++;
                $display("FAIL err_case%0d: adr=%h got lat=%0d err=%b ack=%b pulses=%0d want lat=1 err=1 ack=0 pulses=0",
                         k, ev_adr[k], lat, err, ack, we_cnt - c0);
            end
            n_cmp++;
            if (rdat !== 32'h0000_CC01 || bus.wb_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL err_hold%0d: got dat_o=%h err_after=%b want dat_o=0000cc01 err_after=0", k, rdat, bus.wb_err_o);
            end
        end
    endtask

    task automatic test_sel_zero();
        int lat; logic ack, err; logic [31:0] rdat; logic [9:0] wt; int c0;
        c0 = we_cnt;
        do_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 1 || ack !== 1'b1 || err !== 1'b0 || we_cnt !== c0) begin
            n_fail++;
            $display("FAIL sel0_ctrl: got lat=%0d ack=%b err=%b pulses=%0d want lat=1 ack=1 err=0 pulses=0", lat, ack, err, we_cnt - c0);
        end
        do_xfer(1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 1 || ack !== 1'b1 || err !== 1'b0 || we_cnt !== c0) begin
            n_fail++;
            $display("FAIL sel0_ro: got lat=%0d ack=%b err=%b pulses=%0d want lat=1 ack=1 err=0 pulses=0", lat, ack, err, we_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, c0; logic [31:0] rd; logic [9:0] wt;
        c0 = we_cnt; lat1 = 0; lat2 = 0; wt = '0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 32'h08; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h0;
        while (lat1 < 10 && bus.wb_ack_o !== 1'b1) begin
            @(posedge clk); #1; lat1++;
        end
        rd = bus.wb_dat_o;
        bus.wb_we_i = 1'b1; bus.wb_adr_i = 32'h04; bus.wb_dat_i = 32'h77;
        while (lat2 < 10 && bus.wb_ack_o !== 1'b1 || lat2 == 0) begin
            @(posedge clk); #1;
            wt[lat2] = bus.reg_we;
            lat2++;
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (lat1 !== 2 || rd !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL b2b_read: got lat=%0d dat=%h want lat=2 dat=12345678", lat1, rd);
        end
        n_cmp++;
        if (lat2 !== 3 || wt !== 10'b00_0000_0010 || we_cnt - c0 !== 1 || regs[1] !== 32'h77) begin
            n_fail++;
            $display("FAIL b2b_write: got lat=%0d trace=%b pulses=%0d reg1=%h want lat=3 trace=0000000010 pulses=1 reg1=00000077",
                     lat2, wt, we_cnt - c0, regs[1]);
        end
    endtask

    task automatic test_abort();
        int lat, c0; logic ack, err, seen; logic [31:0] rdat; logic [9:0] wt;
        c0 = we_cnt; seen = 1'b0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 32'h04; bus.wb_dat_i = 32'h1122_3344; bus.wb_sel_i = 4'b0001;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | bus.wb_ack_o | bus.wb_err_o | bus.reg_we;
        end
        n_cmp++;
        if (seen !== 1'b0 || we_cnt !== c0 || regs[1] !== 32'h77) begin
            n_fail++;
            $display("FAIL abort_rmw: got activity=%b pulses=%0d reg1=%h want activity=0 pulses=0 reg1=00000077", seen, we_cnt - c0, regs[1]);
        end
        do_xfer(1'b0, 32'h04, 32'h0, 4'hF, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 2 || ack !== 1'b1 || rdat !== 32'h77) begin
            n_fail++;
            $display("FAIL abort_next: got lat=%0d ack=%b dat=%h want lat=2 ack=1 dat=00000077", lat, ack, rdat);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, c0; logic ack, err; logic [31:0] rdat; logic [9:0] wt;
        c0 = we_cnt;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 32'h04; bus.wb_dat_i = 32'h99; bus.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.reg_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got reg_we=%b want 1", bus.reg_we);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.wb_ack_o, bus.wb_err_o, bus.reg_we} !== 3'b000 || {bus.wb_dat_o, bus.reg_din, bus.reg_addr} !== 66'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ack/err/we=%b dat_o=%h din=%h addr=%0d want all 0",
                     {bus.wb_ack_o, bus.wb_err_o, bus.reg_we}, bus.wb_dat_o, bus.reg_din, bus.reg_addr);
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (we_cnt !== c0 || regs[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_lost: got pulses=%0d reg1=%h want pulses=0 reg1=00000000", we_cnt - c0, regs[1]);
        end
        do_xfer(1'b1, 32'h04, 32'h55, 4'hF, lat, ack, err, rdat, wt);
        do_xfer(1'b0, 32'h04, 32'h0, 4'hF, lat, ack, err, rdat, wt);
        n_cmp++;
        if (lat !== 2 || ack !== 1'b1 || rdat !== 32'h55) begin
            n_fail++;
            $display("FAIL rst_mid_after: got lat=%0d ack=%b dat=%h want lat=2 ack=1 dat=00000055", lat, ack, rdat);
        end
    endtask

    initial begin
        we_cnt       = 0;
        last_addr    = '0;
        last_din     = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_errors();
        test_sel_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regport_bridge.md
# wb_regport_bridge

Wishbone classic slave that acts as the initiator of the simple register port (`we`/`addr`/`din`/`dout`) used by the peripherals on the RV32I Wishbone bus, starting with the timer. It decodes a Wishbone access into a register index and drives single-cycle register writes. Reads return the combinational `dout`. Partial-byte writes are turned into read-modify-write sequences. Accesses that are misaligned, out of range or read-only are answered with `wb_err_o`.

## Interface
Parameters:
- `REG_AW`, 2: width of `reg_addr`; register index = `wb_adr_i[REG_AW+1:2]`
- `NUM_REGS`, 3: valid indexes 0..NUM_REGS-1
- `WR_MASK`, 3'b011: bit i = 1 means index i is writable (timer: ctrl and period writable, value read-only)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `wb_cyc_i` in 1: bus cycle
- `wb_stb_i` in 1: strobe
- `wb_we_i` in 1: 1 = write
- `wb_adr_i` in 32: byte address; upper bits are already decoded by the interconnect
- `wb_dat_i` in 32: write data
- `wb_sel_i` in 4: byte lane enables
- `wb_dat_o` out 32: read data, registered
- `wb_ack_o` out 1: normal termination, registered
- `wb_err_o` out 1: error termination, registered
- `reg_we` out 1: register write strobe, registered
- `reg_addr` out REG_AW: register index, registered
- `reg_din` out 32: register write data, registered
- `reg_dout` in 32: combinational read data of the peripheral for `reg_addr`

## Operation
- **Request**: `wb_cyc_i & wb_stb_i`, sampled only in IDLE.
- **Error check** (in IDLE), any of the following gives an error:
  - `wb_adr_i[1:0] != 0`
  - index ≥ NUM_REGS
  - write with `WR_MASK[index] == 0` and `wb_sel_i != 0`
- **States**: IDLE, RD, RMW, WR, RESP.
  - IDLE → RESP: error, with `wb_err_o <= 1`; no register access.
  - IDLE → RD: read. Sets `reg_addr`.
  - IDLE → WR: write with `sel == 4'hF`. Sets `reg_addr`, `reg_din <= wb_dat_i`, `reg_we <= 1`.
  - IDLE → RMW: write with `sel` partial and nonzero. Sets `reg_addr`.
  - IDLE → RESP: write with `sel == 0`, with `wb_ack_o <= 1`; no `reg_we`.
  - RD → RESP: `wb_dat_o <= reg_dout`, `wb_ack_o <= 1`.
  - RMW → WR: `reg_din` = per byte, `sel[b] ? wb_dat_i[b] : reg_dout[b]`; `reg_we <= 1`.
  - WR → RESP: `reg_we <= 0`, `wb_ack_o <= 1`.
  - RESP → IDLE: `wb_ack_o` and `wb_err_o` cleared.
- **Writes**: `reg_we` is high for exactly one cycle per write transaction; never twice.
- **Abort**: `wb_cyc_i` low in RD or RMW → IDLE, no ack, no `reg_we`. A write already in WR completes; its ack is suppressed if `wb_cyc_i` is low at the WR edge.
- **Read data**: `wb_dat_o` holds its last value outside RESP. It is not cleared.

## Timing
- Reset value of every output is 0; the state is IDLE. Reset is asynchronous, so a mid-transaction reset drops `reg_we`/`ack` immediately and the transaction is lost.
- The request is sampled at edge E0. The ack/err line is high for exactly one cycle:
  - error, or write with sel=0: after E0 (latency 1)
  - read, or full write: after E1 (latency 2); for a full write `reg_we` is high between E0 and E1
  - partial write: after E2 (latency 3); `reg_we` is high between E1 and E2
- Minimum spacing between accepted requests is latency + 1 edges. The RESP cycle lets the master drop `stb`, so no request is ever sampled twice.
- `wb_ack_o` and `wb_err_o` are never high together.

## Structure
- Package `wb_regport_pkg`:
  - state enum (IDLE, RD, RMW, WR, RESP)
  - default parameter constants
  - byte-merge function (sel, new, old) → merged word
- Single module; no sub-module.
- The timer is attached by instantiating this bridge and connecting `reg_*` to the timer's `we`/`addr`/`din`/`dout`.

## Test plan
- Full write: write 0x0000_0064 to 0x04, sel F → `reg_we` for one cycle, addr 1, din 0x64, ack 2 cycles later; then read 0x04 → `wb_dat_o` = 0x64, ack latency 2.
- Partial write: write 0xAABB_CCDD to 0x00 with sel 4'b0010 while ctrl = 0x0000_0001 → `reg_din` = 0x0000_CC01, ack latency 3.
- Error cases, each giving err after 1 cycle with no `reg_we`: write 0x08 (value, read-only), read 0x0C (index 3), access 0x02 (misaligned).
- Write with sel 0 to 0x00 → ack after 1 cycle, `reg_we` never asserted. Back-to-back read then write with `stb` held → each sampled exactly once.
- Abort: drop `wb_cyc_i` in RMW → no `reg_we`, no ack, IDLE. Assert `rst_n` low during WR → all outputs 0 asynchronously and the next transaction works normally.
